// File: rtl/brch_predict.sv
// brch_predict: 2-bit saturating-counter direction predictor with execute-stage
// training, mispredict redirect generation and saturating performance counters.
module brch_predict #(
  parameter int IDX_BITS = 4,
  parameter int PC_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  // fetch-side lookup
  input  logic [PC_W-1:0] fetch_pc,
  input  logic            fetch_is_cond,
  output logic            pred_taken,
  // execute-side resolution
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_is_cond,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic            ex_brchcnd,
  input  logic [PC_W-1:0] ex_target,
  input  logic [PC_W-1:0] ex_pc_plus2,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  // performance statistics
  input  logic            clr_stats,
  output logic [15:0]     br_count,
  output logic [15:0]     mp_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  // Direction table; bit 1 of each entry is the predicted direction.
  logic [1:0] ctr_tbl [ENTRIES];

  logic [IDX_BITS-1:0] fetch_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic [1:0]          fetch_ctr;
  logic [1:0]          ex_ctr;
  logic [1:0]          ex_ctr_next;
  logic                upd;
  logic                train;
  logic                wrong_dir;

  // Instructions are halfword aligned, so PC bit 0 never contributes to the index.
  assign fetch_idx = fetch_pc[IDX_BITS:1];
  assign ex_idx    = ex_pc[IDX_BITS:1];

  assign fetch_ctr = ctr_tbl[fetch_idx];
  assign ex_ctr    = ctr_tbl[ex_idx];

  // A resolving instruction only counts once the stall has dropped.
  assign upd       = ex_valid & ~ex_stall;
  assign train     = upd & ex_is_cond;
  assign wrong_dir = ex_brchcnd ^ ex_pred_taken;

  // Fetch prediction reads the registered table directly: a same-cycle training
  // write to the same index is not bypassed, so fetch sees the old counter.
  always_comb begin
    pred_taken = 1'b0;
    if (!rst && fetch_is_cond) begin
      pred_taken = fetch_ctr[1];
    end
  end

  // Redirect is combinational from the execute inputs so the flush happens in
  // the resolving cycle; the target is selected by the actual outcome.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = ex_brchcnd ? ex_target : ex_pc_plus2;
    if (!rst && upd && wrong_dir) begin
      mispredict = 1'b1;
    end
  end

  // Saturating increment/decrement of the counter being trained.
  always_comb begin
    ex_ctr_next = ex_ctr;
    if (ex_brchcnd) begin
      if (ex_ctr != CTR_STRONG_T) begin
        ex_ctr_next = ex_ctr + 2'd1;
      end
    end else begin
      if (ex_ctr != CTR_STRONG_NT) begin
        ex_ctr_next = ex_ctr - 2'd1;
      end
    end
  end

  // Table write: reset reloads every entry to weak-NT and drops any pending training.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_tbl[i] <= CTR_WEAK_NT;
      end
    end else if (train) begin
      ctr_tbl[ex_idx] <= ex_ctr_next;
    end
  end

  // Resolved-conditional-branch counter; clear wins over increment, holds at max.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      br_count <= '0;
    end else if (train && (br_count != STAT_MAX)) begin
      br_count <= br_count + 16'd1;
    end
  end

  // Misprediction counter covers both conditional branches and jumps.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      mp_count <= '0;
    end else if (mispredict && (mp_count != STAT_MAX)) begin
      mp_count <= mp_count + 16'd1;
    end
  end

endmodule

// File: doc/brch_predict.md
Name: brch_predict

Overview:
- Direction predictor and redirect generator for the 16-bit pipeline.
- In fetch, it looks up a 2-bit saturating counter table indexed by PC and gives a taken/not-taken prediction to the fetch/decode PC logic.
- In execute, it takes the resolved branch condition (the BrchCnd result) with the carried prediction. It trains the table, raises a mispredict redirect with the correct PC, and keeps saturating performance counters.

Parameters:
- IDX_BITS, 4, table index width; table has 2**IDX_BITS entries.
- PC_W, 16, PC / address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_pc  input  PC_W  PC of the instruction in fetch.
- fetch_is_cond  input  1  predecode: fetch instruction is a conditional branch.
- pred_taken  output  1  prediction for fetch_pc (combinational).
- ex_valid  input  1  the execute stage holds a branch or jump resolving this cycle.
- ex_stall  input  1  execute is stalled; suppresses all updates and the redirect.
- ex_is_cond  input  1  the resolving instruction is conditional (BEQZ/BNEZ/BLTZ/BGEZ); 0 means an unconditional jump.
- ex_pc  input  PC_W  PC of the resolving instruction.
- ex_pred_taken  input  1  prediction made in fetch, carried down the pipe.
- ex_brchcnd  input  1  actual outcome (1 = taken; always 1 for jumps).
- ex_target  input  PC_W  taken target.
- ex_pc_plus2  input  PC_W  fall-through PC.
- mispredict  output  1  flush younger stages and redirect fetch (combinational).
- redirect_pc  output  PC_W  correct next PC, valid when mispredict=1.
- clr_stats  input  1  synchronous clear of both perf counters.
- br_count  output  16  resolved conditional branches, saturating.
- mp_count  output  16  mispredictions (cond + jumps), saturating.

Behaviour:
Indexing and prediction:
- Index = pc[IDX_BITS:1]; bit 0 is ignored because instructions are 2-byte aligned.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- pred_taken = fetch_is_cond & ctr[idx(fetch_pc)][1]. It is 0 whenever fetch_is_cond=0.

Update and redirect:
- upd = ex_valid & ~ex_stall.
- Counter training happens only when upd & ex_is_cond:
  - ex_brchcnd=1: ctr = ctr==11 ? 11 : ctr+1.
  - ex_brchcnd=0: ctr = ctr==00 ? 00 : ctr-1.
  - The counter is written at the next clock edge.
- Jumps (ex_is_cond=0) never modify the table.
- mispredict = upd & (ex_brchcnd != ex_pred_taken). This is 0-cycle latency from the ex inputs.
- redirect_pc = ex_brchcnd ? ex_target : ex_pc_plus2. It is driven every cycle and meaningful only with mispredict.
- A jump carried with ex_pred_taken=0 therefore always mispredicts and redirects to ex_target.
- Read/write collision: if fetch reads the index being trained in the same cycle, pred_taken returns the pre-update value. There is no bypass.

Performance counters:
- br_count increments when upd & ex_is_cond.
- mp_count increments when mispredict.
- Both hold at 16'hFFFF (no wrap).
- clr_stats=1 zeroes both. Clear has priority over an increment in the same cycle.

Reset:
- While rst=1 at an edge:
  - all table entries become 01 (weak-NT);
  - br_count and mp_count become 0.
- With rst asserted, mispredict is forced 0 and pred_taken is forced 0.
- Reset mid-training discards the pending update. Reset has priority over clr_stats and over training.

Stall:
- ex_stall=1 holds table and counters unchanged and forces mispredict=0, even if ex_valid=1.
- The same instruction resolves once, when the stall drops.

Test Plan:
1. Reset, then fetch_pc=0x0010 with fetch_is_cond=1 -> pred_taken=0. A fresh reset table reads entry 01 everywhere.
2. Train branch at ex_pc=0x0010 taken twice (ex_pred_taken=0 then 0):
   - mispredict=1 both cycles, redirect_pc=ex_target=0x0040;
   - entry goes 01->10->11; fetch of 0x0010 gives pred_taken=1.
   - Then one not-taken with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x0012, entry=10, pred_taken still 1.
3. Saturation:
   - 5 taken updates on one index -> entry stays 11;
   - 5 not-taken -> stays 00;
   - aliasing: PCs 0x0002 and 0x0022 (IDX_BITS=4) share the entry.
4. Jump: ex_is_cond=0, ex_brchcnd=1, ex_pred_taken=0, ex_target=0x1234 -> mispredict=1, redirect_pc=0x1234, table unchanged, br_count unchanged, mp_count+1.
5. Stall and collision:
   - ex_valid=1, ex_stall=1, wrong prediction -> mispredict=0, no counter change; drop stall -> single update and single mp_count increment.
   - Same-cycle fetch of the trained index returns the old prediction.
6. Stats:
   - preload by driving 65,540 mispredicts -> mp_count=0xFFFF held.
   - clr_stats with a simultaneous mispredict -> both counts 0.
   - rst asserted during an update -> table returns to all 01.
